// File: rtl/ram_burst_ctrl.sv
// ---------------------------------------------------------------------------
// ram_burst_ctrl
//
// Burst controller between a command/stream interface and a single-port
// synchronous RAM (read data returned one cycle after the address).
// A write burst streams i_wdata straight onto the RAM port. A read burst
// issues RAM reads into a 2-entry output FIFO and presents them on a
// valid/ready stream. o_done pulses for one cycle after every completed burst.
//
// Ports
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_cmd_valid / o_cmd_ready   command handshake
//   i_cmd_write                 1 = write burst, 0 = read burst
//   i_cmd_addr                  burst start address
//   i_cmd_len                   burst length minus one
//   i_wr_valid / o_wr_ready     write-data stream handshake
//   i_wdata                     write-data word
//   o_rd_valid / i_rd_ready     read-data stream handshake
//   o_rdata, o_rd_last          read-data word, last word of the burst
//   o_done                      one-cycle burst-complete pulse
//   o_mem_we, o_mem_addr,
//   o_mem_wdata, i_mem_rdata    RAM port
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a command; o_cmd_ready high
// S_WRITE | streaming write beats into the RAM
// S_READ  | issuing RAM reads while the output FIFO has room
// S_DRAIN | all reads issued; waiting for the last word to be popped
// ---------------------------------------------------------------------------
module ram_burst_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [ADDR_WIDTH-1:0] i_cmd_len,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rd_last,
    output logic                  o_done,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    // Count is one bit wider than the address so a full-depth burst fits.
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
    localparam logic [CW-1:0]         C_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CW-1:0]         r_count;
    logic                  r_done;
    logic                  r_inflight;
    logic                  r_inflight_last;

    logic [DATA_WIDTH-1:0] r_fifo_data [2];
    logic [1:0]            r_fifo_last;
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_fifo_cnt;

    logic                  w_cmd_ready;
    logic                  w_accept;
    logic                  w_rd_valid;
    logic                  w_pop;
    logic                  w_pop_last;
    logic                  w_wr_beat;
    logic [2:0]            w_slots;
    logic                  w_rd_issue;
    logic                  w_issue_last;
    logic [CW-1:0]         w_len_p1;

    assign w_cmd_ready = (r_state == S_IDLE) & ~i_reset;
    assign w_accept    = i_cmd_valid & w_cmd_ready;
    assign w_rd_valid  = (r_fifo_cnt != 2'd0) & ~i_reset;
    assign w_pop       = w_rd_valid & i_rd_ready;
    assign w_pop_last  = w_pop & r_fifo_last[r_rd_ptr];
    assign w_wr_beat   = (r_state == S_WRITE) & i_wr_valid & ~i_reset;
    assign w_len_p1    = {1'b0, i_cmd_len} + C_ONE;

    // Slots that will be committed after this edge. A pop this cycle frees a
    // slot in time for the next issue, which keeps a back-to-back read stream
    // running at one word per cycle without ever overfilling the FIFO.
    assign w_slots = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};

    // The first read is issued in the accept cycle itself (address taken
    // straight from the command) so the first word reaches the output two
    // cycles after accept.
    always_comb begin
        w_rd_issue   = 1'b0;
        w_issue_last = 1'b0;
        if (!i_reset) begin
            if (w_accept && !i_cmd_write) begin
                w_rd_issue   = 1'b1;
                w_issue_last = (i_cmd_len == '0);
            end else if (r_state == S_READ && w_slots < 3'd2) begin
                w_rd_issue   = 1'b1;
                w_issue_last = (r_count == C_ONE);
            end
        end
    end

    // Burst sequencing FSM
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_count         <= '0;
            r_done          <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_rd_issue;
            r_inflight_last <= w_rd_issue & w_issue_last;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (i_cmd_write) begin
                            r_addr  <= i_cmd_addr;
                            r_count <= w_len_p1;
                            r_state <= S_WRITE;
                        end else begin
                            // First word already issued this cycle.
                            r_addr  <= i_cmd_addr + A_ONE;
                            r_count <= {1'b0, i_cmd_len};
                            r_state <= (i_cmd_len == '0) ? S_DRAIN : S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_wr_beat) begin
                        r_addr  <= r_addr + A_ONE;
                        r_count <= r_count - C_ONE;
                        if (r_count == C_ONE) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (w_rd_issue) begin
                        r_addr  <= r_addr + A_ONE;
                        r_count <= r_count - C_ONE;
                        if (r_count == C_ONE) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output FIFO control: push the RAM word one cycle after its issue.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fifo_last <= '0;
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_fifo_cnt  <= '0;
        end else begin
            if (r_inflight) begin
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // FIFO storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge i_clk) begin
        if (r_inflight && !i_reset) begin
            r_fifo_data[r_wr_ptr] <= i_mem_rdata;
        end
    end

    assign o_cmd_ready = w_cmd_ready;
    assign o_wr_ready  = (r_state == S_WRITE) & ~i_reset;
    assign o_mem_we    = w_wr_beat;
    assign o_mem_addr  = i_reset ? '0 : ((r_state == S_IDLE) ? i_cmd_addr : r_addr);
    assign o_mem_wdata = i_wdata;
    assign o_rd_valid  = w_rd_valid;
    assign o_rdata     = r_fifo_data[r_rd_ptr];
    assign o_rd_last   = w_rd_valid & r_fifo_last[r_rd_ptr];
    assign o_done      = r_done & ~i_reset;

endmodule

// File: doc/ram_burst_ctrl.md
RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: RAM address width; burst length and address arithmetic are modulo 2^ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 8: RAM data word width.
REQ-003 i_clk  in  1  single clock; all logic on rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_cmd_valid  in  1  command request.
REQ-006 o_cmd_ready  out  1  command accepted when i_cmd_valid & o_cmd_ready.
REQ-007 i_cmd_write  in  1  1 = burst write, 0 = burst read.
REQ-008 i_cmd_addr  in  ADDR_WIDTH  burst start address.
REQ-009 i_cmd_len  in  ADDR_WIDTH  burst length minus one (1 to 2^ADDR_WIDTH words).
REQ-010 i_wr_valid / o_wr_ready  in / out  1 / 1  write-data stream handshake.
REQ-011 i_wdata  in  DATA_WIDTH  write-data word.
REQ-012 o_rd_valid / i_rd_ready  out / in  1 / 1  read-data stream handshake.
REQ-013 o_rdata  out  DATA_WIDTH  read-data word.
REQ-014 o_rd_last  out  1  high with the final word of a read burst.
REQ-015 o_done  out  1  one-cycle pulse when a burst completes.
REQ-016 o_mem_we  out  1  RAM write enable.
REQ-017 o_mem_addr  out  ADDR_WIDTH  RAM address.
REQ-018 o_mem_wdata  out  DATA_WIDTH  RAM write data.
REQ-019 i_mem_rdata  in  DATA_WIDTH  RAM read data, valid exactly one cycle after the address is presented.

Function
REQ-020 The FSM shall have states IDLE, WRITE, READ and DRAIN.
REQ-021 o_cmd_ready shall be 1 only in IDLE with i_reset low.
- On accept: latch address and remaining count = i_cmd_len+1.
- Next state is WRITE if i_cmd_write, else READ.
REQ-022 In WRITE:
- o_wr_ready = 1.
- o_mem_we = i_wr_valid; o_mem_addr = current address; o_mem_wdata = i_wdata (combinational).
- Each accepted beat increments the address (wraps 2^ADDR_WIDTH-1 -> 0) and decrements the count.
REQ-023 In WRITE, the beat that takes the count to 0 shall return the FSM to IDLE and pulse o_done in the following cycle.
REQ-024 In READ, the block shall issue a RAM read (o_mem_we = 0, o_mem_addr = current address) only when FIFO occupancy + in-flight reads < 2.
- Each issue increments the address (with wrap) and decrements the count.
- Issuing the last read moves the FSM to DRAIN.
REQ-025 Returned i_mem_rdata shall be captured into a 2-entry output FIFO one cycle after issue, tagged last if it belongs to the final issued address.
REQ-026 o_rd_valid shall equal FIFO not-empty; o_rdata and o_rd_last shall come from the FIFO head; the head pops on o_rd_valid & i_rd_ready.
REQ-027 o_rdata and o_rd_last shall hold stable while o_rd_valid & ~i_rd_ready; no word is dropped or duplicated under any i_rd_ready pattern.
REQ-028 Read latency: with i_rd_ready held high, the first word shall appear on o_rd_valid 2 cycles after command accept, and subsequent words every cycle.
REQ-029 In DRAIN: no RAM reads; when the last-tagged word pops, the FSM shall go to IDLE and pulse o_done the next cycle.
REQ-030 o_mem_we shall be 0 in every state other than WRITE.
REQ-031 i_wr_valid outside WRITE and i_rd_ready with the FIFO empty shall be ignored.
REQ-032 A full-depth burst (i_cmd_len = 2^ADDR_WIDTH-1) shall touch every address exactly once, ending at start-1 modulo depth.

Reset
REQ-033 While i_reset is high at a clock edge:
- State becomes IDLE; FIFO and in-flight flag clear.
- o_rd_valid, o_rd_last, o_done, o_mem_we, o_wr_ready and o_cmd_ready are 0; o_mem_addr is 0.
REQ-034 Reset mid-burst shall abort the burst without o_done, discard buffered read data, and perform no further RAM writes.
- o_cmd_ready returns to 1 in the first cycle with i_reset low.

Verification
REQ-035 Write addr 3, len 3, data 0xA0..0xA3 with continuous i_wr_valid -> 4 RAM writes to addresses 3,4,5,6 on consecutive cycles, then o_done pulse.
REQ-036 Read addr 3, len 3, i_rd_ready = 1 -> o_rdata 0xA0,0xA1,0xA2,0xA3 on consecutive cycles starting 2 cycles after accept; o_rd_last only on 0xA3.
REQ-037 Same read with i_rd_ready toggling 1,0,0,1,0,1... -> identical 4-word sequence, each word held while stalled, no drops or duplicates.
REQ-038 ADDR_WIDTH = 4: write addr 14, len 2 -> RAM writes to addresses 14,15,0. Read back -> same data in order.
REQ-039 Full burst addr 0, len 15 write then read -> all 16 words match; o_done pulses once per burst.
REQ-040 Assert i_reset after 2 of 4 write beats -> no further o_mem_we, no o_done. Then i_reset low -> o_cmd_ready = 1 and a new read returns the 2 written words.
